lifo: RTL and testbench
=======================

LIFO -- requirements
Module: lifo

Interface
REQ-001 Parameter DWIDTH, default 8, data word width in bits.
REQ-002 Parameter AWIDTH, default 4, address width; depth DEPTH = 2**AWIDTH words (16 by default).
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 srst_i  input  1  reset, synchronous, active-low.
REQ-005 wrreq_i  input  1  push request, sampled at the rising edge.
REQ-006 data_i  input  DWIDTH  push data, sampled with wrreq_i.
REQ-007 rdreq_i  input  1  pop request, sampled at the rising edge.
REQ-008 q_o  output  DWIDTH  registered pop data.
REQ-009 empty_o  output  1  high when the stack holds 0 words.
REQ-010 full_o  output  1  high when the stack holds DEPTH words.
REQ-011 usedw_o  output  AWIDTH+1  number of stored words, range 0..DEPTH.

Function
REQ-012 Storage SHALL be a DEPTH x DWIDTH memory with a stack pointer equal to the word count (the next free slot).
REQ-013 Push (wrreq_i=1, full_o=0): at the edge, write data_i at slot usedw_o and increment usedw_o.
REQ-014 Pop (rdreq_i=1, wrreq_i=0, empty_o=0): at the edge, load q_o with the word at slot usedw_o-1 (the most recent push) and decrement usedw_o.
REQ-015 Pop latency: q_o SHALL show the popped word from the edge that sampled rdreq_i until the next pop; back-to-back pops SHALL return consecutive words in reverse push order.
REQ-016 q_o SHALL hold its value on every cycle without an accepted pop.
REQ-017 Simultaneous wrreq_i=1 and rdreq_i=1: the write takes priority as a normal push (if not full); the read is ignored; q_o is unchanged.
REQ-018 A push while full_o=1 SHALL be ignored: no memory write and no change to usedw_o or the flags.
REQ-019 A pop while empty_o=1 SHALL be ignored: q_o and usedw_o are unchanged.
REQ-020 usedw_o, full_o and empty_o SHALL reflect the count after the most recent edge (registered count, one-cycle update); full_o = (usedw_o == DEPTH); empty_o = (usedw_o == 0).
REQ-021 Count arithmetic SHALL be AWIDTH+1 bits wide with no wrap-around; usedw_o never exceeds DEPTH or goes below 0.
REQ-022 Data pushed after a pop SHALL overwrite the freed slot, and the next pop SHALL return the newest data.

Reset
REQ-023 When srst_i=0 at a rising edge: usedw_o=0, empty_o=1, full_o=0, q_o=0; requests in that cycle are ignored.
REQ-024 Reset SHALL take priority over any push or pop, including mid-fill or mid-drain; memory contents are not cleared and are not readable afterwards.

Verification
REQ-025 Fill: 16 consecutive pushes from empty -> usedw_o counts 1..16 one per cycle; full_o=1 only after the 16th; a 17th push is ignored (usedw_o stays 16).
REQ-026 Drain: 16 consecutive pops -> q_o returns the 16 words in reverse push order, one per cycle; usedw_o counts 15..0; empty_o=1 after the last pop; a further pop leaves q_o unchanged.
REQ-027 Random pauses: fill, then drain, with wrreq_i/rdreq_i randomly toggling each cycle -> usedw_o tracks the accepted requests exactly and data stays in LIFO order.
REQ-028 Full boundary: from full, pop, push, pop, push -> full_o toggles 1,0,1,0,1 and each pop returns the most recently pushed word.
REQ-029 Empty boundary: from empty, push, pop, push, pop -> empty_o toggles 1,0,1,0,1 and each pop returns the word just pushed.
REQ-030 Simultaneous/reset: wrreq_i=rdreq_i=1 at count 5 -> count becomes 6 and q_o is unchanged; srst_i=0 at count 8 -> usedw_o=0, empty_o=1, q_o=0 on the next cycle.

Source files
------------

// File: rtl/lifo.sv
// Synchronous LIFO stack: DEPTH x DWIDTH storage with a registered pop output.
// The stack pointer doubles as the word count (next free slot).
module lifo #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] CNT_FULL = {1'b1, {AWIDTH{1'b0}}};

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AWIDTH:0]   r_cnt;
  logic [DWIDTH-1:0] r_q;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [AWIDTH:0]   w_cnt_dec;
  logic [AWIDTH-1:0] w_wr_addr;
  logic [AWIDTH-1:0] w_rd_addr;

  assign w_full    = (r_cnt == CNT_FULL);
  assign w_empty   = (r_cnt == '0);
  // Write wins when both requests arrive together.
  assign w_push    = wrreq_i & ~w_full;
  assign w_pop     = rdreq_i & ~wrreq_i & ~w_empty;
  assign w_cnt_dec = r_cnt - CNT_ONE;
  assign w_wr_addr = r_cnt[AWIDTH-1:0];
  assign w_rd_addr = w_cnt_dec[AWIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      r_cnt <= '0;
      r_q   <= '0;
    end else if (w_push) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else if (w_pop) begin
      r_cnt <= w_cnt_dec;
      r_q   <= r_mem[w_rd_addr];
    end
  end

  // Storage is never cleared; the count alone decides what is readable.
  always_ff @(posedge clk_i) begin
    if (srst_i && w_push) begin
      r_mem[w_wr_addr] <= data_i;
    end
  end

  assign q_o     = r_q;
  assign usedw_o = r_cnt;
  assign empty_o = w_empty;
  assign full_o  = w_full;

endmodule

// File: tb/tb_lifo.sv
// Bench for lifo: vector table, directed corner sequences and
// randomized traffic against a queue-based stack model.
module tb_lifo;

  logic       clk = 1'b0;
  logic       srst;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] data;
  logic [7:0] q;
  logic       empty;
  logic       full;
  logic [4:0] usedw;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_stk [$];
  logic [7:0] m_q;

  typedef struct {
    logic       srst;
    logic       wr;
    logic       rd;
    logic [7:0] data;
    logic [7:0] q;
    logic [4:0] used;
    logic       e;
    logic       f;
  } vec_t;

  vec_t tbl [10];

  lifo #(.DWIDTH(8), .AWIDTH(4)) dut (
    .clk_i   (clk),
    .srst_i  (srst),
    .wrreq_i (wrreq),
    .data_i  (data),
    .rdreq_i (rdreq),
    .q_o     (q),
    .empty_o (empty),
    .full_o  (full),
    .usedw_o (usedw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural stack: reset clears, push wins, pop returns newest word.
  task automatic step(input logic rs, input logic wr,
                      input logic rd, input logic [7:0] d);
    @(negedge clk);
    srst = rs; wrreq = wr; rdreq = rd; data = d;
    @(posedge clk);
    if (!rs) begin
      m_stk.delete();
      m_q = 8'h00;
    end else if (wr) begin
      if (m_stk.size() < 16) m_stk.push_back(d);
    end else if (rd && m_stk.size() > 0) begin
      m_q = m_stk.pop_back();
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".q"}, int'(q), int'(m_q));
    chk({tag, ".usedw"}, int'(usedw), m_stk.size());
    chk({tag, ".empty"}, int'(empty), int'(m_stk.size() == 0));
    chk({tag, ".full"}, int'(full), int'(m_stk.size() == 16));
  endtask

  initial begin
    srst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
    m_q = 8'h00;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'hA1, 8'h00, 5'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hA1, 5'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'hB2, 8'hA1, 5'd1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hB2, 5'd0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hB2, 5'd0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 8'hC3, 8'hB2, 5'd1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'hD4, 8'hB2, 5'd2, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hD4, 5'd1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hC3, 5'd0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 8'hEE, 8'h00, 5'd0, 1'b1, 1'b0};

    // Reset state
    step(1'b0, 1'b1, 1'b1, 8'h55);
    chk("rst.q", int'(q), 0);
    chk("rst.usedw", int'(usedw), 0);
    chk("rst.empty", int'(empty), 1);
    chk("rst.full", int'(full), 0);

    // Empty boundary and simultaneous request table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].srst, tbl[i].wr, tbl[i].rd, tbl[i].data);
      chk($sformatf("tbl%0d.q", i), int'(q), int'(tbl[i].q));
      chk($sformatf("tbl%0d.usedw", i), int'(usedw), int'(tbl[i].used));
      chk($sformatf("tbl%0d.empty", i), int'(empty), int'(tbl[i].e));
      chk($sformatf("tbl%0d.full", i), int'(full), int'(tbl[i].f));
    end

    // Fill: count 1..16, full only after 16th, 17th ignored
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
      chk_model($sformatf("fill%0d", i));
    end
    chk("fill.usedw16", int'(usedw), 16);

    // Full boundary: pop, push, pop, push
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("fb.pop1.q", int'(q), 8'h1F);
    chk("fb.pop1.full", int'(full), 0);
    step(1'b1, 1'b1, 1'b0, 8'h77);
    chk("fb.push1.full", int'(full), 1);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("fb.pop2.q", int'(q), 8'h77);
    chk("fb.pop2.full", int'(full), 0);
    step(1'b1, 1'b1, 1'b0, 8'h88);
    chk_model("fb.push2");

    // Drain: reverse order, then an extra pop is ignored
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk_model($sformatf("drain%0d", i));
    end
    chk("drain.extra.q", int'(q), 8'h10);

    // Simultaneous at count 5, reset at count 8
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h44);
    step(1'b1, 1'b1, 1'b1, 8'h45);
    chk("sim.usedw", int'(usedw), 6);
    chk("sim.q", int'(q), 8'h44);
    step(1'b1, 1'b1, 1'b0, 8'h46);
    step(1'b1, 1'b1, 1'b0, 8'h47);
    chk("pre_rst.usedw", int'(usedw), 8);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("mid_rst.usedw", int'(usedw), 0);
    chk("mid_rst.empty", int'(empty), 1);
    chk("mid_rst.q", int'(q), 0);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk_model("post_rst.pop");

    // Random pauses: fill-biased then drain-biased
    for (int i = 0; i < 400; i++) begin
      logic wr, rd;
      if (i < 200) begin
        wr = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 2) == 0);
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 3) != 0);
      end
      step(1'b1, wr, rd, 8'($urandom));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
